// File: rtl/mem_req_scheduler.sv
// Three-way line-transaction scheduler: dcache, icache and next-line prefetcher
// share one cacheline adapter port, with fixed priority and an icache starvation guard.
module mem_req_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_read,
  input  logic [31:0]  icache_address,
  output logic         icache_resp,
  output logic [255:0] icache_rdata,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [31:0]  dcache_address,
  input  logic [255:0] dcache_wdata,
  output logic         dcache_resp,
  output logic [255:0] dcache_rdata,
  input  logic         pf_read,
  input  logic [31:0]  pf_address,
  output logic         pf_resp,
  output logic [255:0] pf_rdata,
  output logic         adapter_read,
  output logic         adapter_write,
  output logic [31:0]  adapter_address,
  output logic [255:0] adapter_wdata,
  input  logic         adapter_resp,
  input  logic [255:0] adapter_rdata
);

  // state  | meaning
  // IDLE   | no transaction; grant decided here
  // BUSY_I | icache line read in flight
  // BUSY_D | dcache line read or writeback in flight
  // BUSY_P | prefetch line read in flight
  // TURN   | one quiet cycle so the served requester can drop its request

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, BUSY_P, TURN} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  starve_cnt, starve_cnt_nxt;
  logic           op_write, op_write_nxt;
  logic [31:0]    addr_q, addr_nxt;
  logic [255:0]   wdata_q, wdata_nxt;
  logic           dcache_req;
  logic           starved;

  assign dcache_req = dcache_read | dcache_write;
  assign starved    = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    op_write_nxt   = op_write;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    case (state)
      IDLE: begin
        if (dcache_req && !(starved && icache_read)) begin
          state_nxt    = BUSY_D;
          addr_nxt     = dcache_address;
          wdata_nxt    = dcache_wdata;
          op_write_nxt = dcache_write;
          if (icache_read && !starved) starve_cnt_nxt = starve_cnt + 1'b1;
        end else if (icache_read) begin
          state_nxt      = BUSY_I;
          addr_nxt       = icache_address;
          op_write_nxt   = 1'b0;
          starve_cnt_nxt = '0;
        end else if (pf_read) begin
          state_nxt    = BUSY_P;
          addr_nxt     = pf_address;
          op_write_nxt = 1'b0;
        end
      end
      BUSY_I, BUSY_D, BUSY_P: begin
        if (adapter_resp) state_nxt = TURN;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      op_write   <= op_write_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
    end
  end

  // Command is a pure decode of the registered state, so reset drops it on the next edge.
  assign adapter_read    = (state == BUSY_I) || (state == BUSY_P) ||
                           ((state == BUSY_D) && !op_write);
  assign adapter_write   = (state == BUSY_D) && op_write;
  assign adapter_address = addr_q;
  assign adapter_wdata   = wdata_q;

  assign icache_resp = (state == BUSY_I) && adapter_resp;
  assign dcache_resp = (state == BUSY_D) && adapter_resp;
  assign pf_resp     = (state == BUSY_P) && adapter_resp;

  assign icache_rdata = adapter_rdata;
  assign dcache_rdata = adapter_rdata;
  assign pf_rdata     = adapter_rdata;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: expected grants are queued as requests are
// raised and checked against the adapter command and the steered resp pulses.
module tb_mem_req_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_read, dcache_read, dcache_write, pf_read;
  logic [31:0]  icache_address, dcache_address, pf_address;
  logic [255:0] dcache_wdata;
  logic         icache_resp, dcache_resp, pf_resp;
  logic [255:0] icache_rdata, dcache_rdata, pf_rdata;
  logic         adapter_read, adapter_write, adapter_resp;
  logic [31:0]  adapter_address;
  logic [255:0] adapter_wdata, adapter_rdata;

  always #5 clk = ~clk;

  mem_req_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_resp(icache_resp), .icache_rdata(icache_rdata),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
    .pf_read(pf_read), .pf_address(pf_address),
    .pf_resp(pf_resp), .pf_rdata(pf_rdata),
    .adapter_read(adapter_read), .adapter_write(adapter_write),
    .adapter_address(adapter_address), .adapter_wdata(adapter_wdata),
    .adapter_resp(adapter_resp), .adapter_rdata(adapter_rdata)
  );

  localparam logic [1:0] W_I = 2'd0, W_D = 2'd1, W_P = 2'd2;

  typedef struct {
    logic [1:0]   who;
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_resp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic [31:0] addr, input logic wr,
                      input logic [255:0] wdata);
    exp_t e;
    e.who = who; e.addr = addr; e.wr = wr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // One granted transaction: wait for the command, compare with the head of the
  // scoreboard, answer after `delay` command cycles, then check the TURN cycle.
  task automatic transact(input int delay, input bit reissue, input int gap, input bit raise_i);
    exp_t e;
    logic [255:0] rd;
    logic [2:0] resp_exp;
    int n = 0;
    rd = {8{$urandom}};
    while (!(adapter_read || adapter_write) && n < 20) begin
      step();
      n++;
    end
    chk("cmd_seen", {adapter_read | adapter_write}, 1'b1);
    e = sb.pop_front();
    if (gap > 0) chk("turn_gap", cyc - last_resp, gap);
    chk("addr", adapter_address, e.addr);
    chk("cmd", {adapter_read, adapter_write}, {!e.wr, e.wr});
    if (e.wr) chk("wdata", adapter_wdata, e.wdata);
    for (int i = 1; i < delay; i++) begin
      if (!reissue) begin
        case (e.who)
          W_I: icache_address = $urandom;
          W_D: begin dcache_address = $urandom; dcache_wdata = {8{$urandom}}; end
          default: pf_address = $urandom;
        endcase
      end
      if (raise_i && i == 2) begin
        icache_address = 32'h0000_7000;
        icache_read    = 1'b1;
      end
      step();
      chk("cmd_steady", {adapter_read, adapter_write}, {!e.wr, e.wr});
      chk("addr_steady", adapter_address, e.addr);
      if (e.wr) chk("wdata_steady", adapter_wdata, e.wdata);
      chk("no_early_resp", {icache_resp, dcache_resp, pf_resp}, 3'b000);
    end
    adapter_resp  = 1'b1;
    adapter_rdata = rd;
    #1;
    resp_exp = (e.who == W_I) ? 3'b100 : (e.who == W_D) ? 3'b010 : 3'b001;
    chk("resp_vec", {icache_resp, dcache_resp, pf_resp}, resp_exp);
    chk("i_rdata", icache_rdata, rd);
    chk("d_rdata", dcache_rdata, rd);
    chk("p_rdata", pf_rdata, rd);
    last_resp = cyc;
    step();
    adapter_resp = 1'b0;
    if (!reissue) begin
      case (e.who)
        W_I: icache_read = 1'b0;
        W_D: begin dcache_read = 1'b0; dcache_write = 1'b0; end
        default: pf_read = 1'b0;
      endcase
    end
    #1;
    chk("turn_quiet", {adapter_read, adapter_write, icache_resp, dcache_resp, pf_resp}, 5'b0);
  endtask

  initial begin
    logic [255:0] pat_a5;
    pat_a5 = {32{8'hA5}};
    rst = 1'b1;
    icache_read = 0; dcache_read = 0; dcache_write = 0; pf_read = 0;
    icache_address = 0; dcache_address = 0; pf_address = 0; dcache_wdata = 0;
    adapter_resp = 0; adapter_rdata = 0;
    step();
    step();
    chk("rst_cmd", {adapter_read, adapter_write}, 2'b00);
    chk("rst_addr", adapter_address, 32'h0);
    chk("rst_wdata", adapter_wdata, 256'h0);
    chk("rst_resp", {icache_resp, dcache_resp, pf_resp}, 3'b000);
    rst = 1'b0;
    step();

    // lone icache read
    icache_address = 32'h0000_1000;
    icache_read    = 1'b1;
    push(W_I, 32'h0000_1000, 1'b0, '0);
    step();
    chk("lone_i_t1", {adapter_read, adapter_address}, {1'b1, 32'h0000_1000});
    transact(8, 1'b0, 0, 1'b0);

    // all three at once: dcache write, then icache, then prefetch
    dcache_address = 32'h8000_0040; dcache_wdata = pat_a5; dcache_write = 1'b1;
    icache_address = 32'h0000_2000; icache_read = 1'b1;
    pf_address     = 32'h0000_3000; pf_read = 1'b1;
    push(W_D, 32'h8000_0040, 1'b1, pat_a5);
    push(W_I, 32'h0000_2000, 1'b0, '0);
    push(W_P, 32'h0000_3000, 1'b0, '0);
    transact(4, 1'b0, 0, 1'b0);
    transact(3, 1'b0, 3, 1'b0);
    transact(5, 1'b0, 3, 1'b0);

    // starvation guard: dcache held with icache waiting
    step();
    dcache_address = 32'h0000_4000; dcache_read = 1'b1;
    icache_address = 32'h0000_5000; icache_read = 1'b1;
    for (int k = 0; k < 4; k++) push(W_D, 32'h0000_4000, 1'b0, '0);
    push(W_I, 32'h0000_5000, 1'b0, '0);
    push(W_D, 32'h0000_4000, 1'b0, '0);
    for (int k = 0; k < 4; k++) transact(2, 1'b1, (k == 0) ? 0 : 3, 1'b0);
    transact(2, 1'b0, 3, 1'b0);
    chk("starve_cnt_clr", dut.starve_cnt, 3'd0);
    transact(2, 1'b0, 3, 1'b0);

    // prefetch in flight, icache arrives mid-transaction
    step();
    pf_address = 32'h0000_6000; pf_read = 1'b1;
    push(W_P, 32'h0000_6000, 1'b0, '0);
    push(W_I, 32'h0000_7000, 1'b0, '0);
    transact(6, 1'b0, 0, 1'b1);
    transact(3, 1'b0, 3, 1'b0);

    // reset while BUSY_D, then regrant of the held request
    step();
    dcache_address = 32'h0000_9000; dcache_read = 1'b1;
    step();
    chk("pre_rst_cmd", {adapter_read, adapter_address}, {1'b1, 32'h0000_9000});
    step();
    rst = 1'b1;
    adapter_resp = 1'b1;
    step();
    chk("rst_busy_cmd", {adapter_read, adapter_write}, 2'b00);
    chk("rst_busy_addr", adapter_address, 32'h0);
    chk("rst_busy_resp", {icache_resp, dcache_resp, pf_resp}, 3'b000);
    rst = 1'b0;
    adapter_resp = 1'b0;
    push(W_D, 32'h0000_9000, 1'b0, '0);
    transact(4, 1'b0, 0, 1'b0);

    // spurious adapter_resp in IDLE
    step();
    adapter_resp = 1'b1;
    #1;
    chk("spur_resp", {icache_resp, dcache_resp, pf_resp}, 3'b000);
    step();
    adapter_resp = 1'b0;
    chk("spur_cmd", {adapter_read, adapter_write}, 2'b00);
    dcache_address = 32'h0000_A000; dcache_wdata = {8{32'h1234_5678}}; dcache_write = 1'b1;
    push(W_D, 32'h0000_A000, 1'b1, {8{32'h1234_5678}});
    step();
    chk("spur_then_grant", adapter_write, 1'b1);
    transact(3, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
